// File: rtl/fifo_rd_packer.sv
// Drain stage for a standard-mode fifo_sync: packs pPACK narrow entries LSB-first
// into one wide word on a registered valid/ready port, with flush and idle-timeout partial emits.
module fifo_rd_packer #(
  parameter int pIN_WIDTH = 8,
  parameter int pPACK     = 4,
  parameter int pTIMEOUT  = 16,
  localparam int pCNT_W   = $clog2(pPACK) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fifo_empty,
  output logic                         fifo_ren,
  input  logic [pIN_WIDTH-1:0]         fifo_rdata,
  input  logic                         flush,
  output logic [pIN_WIDTH*pPACK-1:0]   out_data,
  output logic [pCNT_W-1:0]            out_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int pIDLE_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT + 1) : 1;
  localparam logic [pIDLE_W-1:0] IDLE_LAST = pIDLE_W'((pTIMEOUT > 0) ? pTIMEOUT - 1 : 0);
  localparam logic [pCNT_W-1:0]  PACK_N    = pCNT_W'(pPACK);
  localparam logic [pCNT_W:0]    PACK_N1   = (pCNT_W + 1)'(pPACK);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t                        r_state, w_state_next;
  logic [pIN_WIDTH-1:0]          r_acc [pPACK];
  logic [pCNT_W-1:0]             r_acc_cnt;
  logic                          r_rd_pend;
  logic [pIDLE_W-1:0]            r_idle_cnt;
  logic                          r_flush_lat;
  logic [pIN_WIDTH*pPACK-1:0]    r_out_data;
  logic [pCNT_W-1:0]             r_out_count;
  logic                          r_out_valid;

  logic                          w_out_free, w_xfer, w_ren, w_idle_cond, w_idle_hit, w_flush_take;
  logic [pCNT_W-1:0]             w_acc_cnt_eff, w_acc_cnt_next, w_land_lane;
  logic [pIN_WIDTH*pPACK-1:0]    w_pack;

  // Lanes at or above the current count are forced to zero in the outgoing word.
  genvar gi;
  generate
    for (gi = 0; gi < pPACK; gi++) begin : g_lane
      assign w_pack[gi*pIN_WIDTH +: pIN_WIDTH] = (pCNT_W'(gi) < r_acc_cnt) ? r_acc[gi] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_out_free   = !r_out_valid || out_ready;
    w_xfer       = ((r_state != ST_EMIT) && (r_acc_cnt == PACK_N) && w_out_free) ||
                   ((r_state == ST_EMIT) && w_out_free);
    w_acc_cnt_eff = w_xfer ? '0 : r_acc_cnt;
    w_ren = (r_state == ST_FILL) && !fifo_empty &&
            (({1'b0, w_acc_cnt_eff} + {{pCNT_W{1'b0}}, r_rd_pend}) < PACK_N1);
    // A landing entry during a transfer starts the next word in lane 0.
    w_land_lane = w_xfer ? '0 : r_acc_cnt;
    if (r_rd_pend) w_acc_cnt_next = w_land_lane + pCNT_W'(1);
    else           w_acc_cnt_next = w_acc_cnt_eff;
    w_idle_cond  = (r_state == ST_FILL) && (r_acc_cnt != '0) && fifo_empty && !r_rd_pend;
    w_idle_hit   = (pTIMEOUT != 0) && (r_idle_cnt == IDLE_LAST) && (r_acc_cnt != '0);
    w_flush_take = (r_state == ST_FILL) && r_flush_lat;
    case (r_state)
      ST_FILL:  if (r_flush_lat || w_idle_hit) w_state_next = ST_DRAIN;
      ST_DRAIN: if (!r_rd_pend) w_state_next = (w_acc_cnt_next != '0) ? ST_EMIT : ST_FILL;
      ST_EMIT:  if (w_out_free) w_state_next = ST_FILL;
      default:  w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < pPACK; i++) r_acc[i] <= '0;
      r_acc_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_idle_cnt  <= '0;
      r_flush_lat <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rd_pend   <= w_ren;
      r_acc_cnt   <= w_acc_cnt_next;
      r_flush_lat <= flush || (r_flush_lat && !w_flush_take);
      for (int i = 0; i < pPACK; i++) begin
        if (r_rd_pend && (w_land_lane == pCNT_W'(i))) r_acc[i] <= fifo_rdata;
      end
      if (!w_idle_cond)           r_idle_cnt <= '0;
      else if (r_idle_cnt != '1)  r_idle_cnt <= r_idle_cnt + pIDLE_W'(1);
      if (w_xfer) begin
        r_out_data  <= w_pack;
        r_out_count <= r_acc_cnt;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_ren  = w_ren;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;
  assign busy      = (r_acc_cnt != '0) || r_rd_pend || r_out_valid || (r_state != ST_FILL);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue-based standard-mode FIFO feeds the DUT,
// a negedge monitor records every accepted word, and chk_val compares against hand-computed values.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_ren;
  logic [7:0]  fifo_rdata = '0;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  logic        push_en = 1'b0;
  logic [7:0]  push_data = '0;
  logic [7:0]  fq[$];
  int          pops = 0;
  int          underflows = 0;
  logic [31:0] cap_data[$];
  logic [2:0]  cap_cnt[$];

  int n_total = 0;
  int n_bad   = 0;
  int cap_base;
  int pop_base;
  int waited;

  always #5 clk = ~clk;

  fifo_rd_packer #(.pIN_WIDTH(8), .pPACK(4), .pTIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // Standard-mode FIFO: registered empty, rdata valid the cycle after an accepted ren.
  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_rdata <= '0;
    end else begin
      if (fifo_ren) begin
        if (fq.size() == 0) underflows <= underflows + 1;
        else begin
          fifo_rdata <= fq.pop_front();
          pops <= pops + 1;
        end
      end
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_cnt.push_back(out_count);
      $display("word data=%08h count=%0d t=%0t", out_data, out_count, $time);
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("chk %s: %0h ok", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      push_en   = 1'b1;
      push_data = first + 8'(k);
      tick(1);
    end
    push_en = 1'b0;
  endtask

  task automatic wait_words(input int n, input int bound, output int w);
    w = 0;
    while ((cap_data.size() < cap_base + n) && (w < bound)) begin
      tick(1);
      w++;
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] d, input logic [2:0] c);
    if (cap_data.size() > cap_base + idx) begin
      chk_val({tag, "_data"}, 64'(cap_data[cap_base+idx]), 64'(d));
      chk_val({tag, "_cnt"}, 64'(cap_cnt[cap_base+idx]), 64'(c));
    end else begin
      chk_val({tag, "_present"}, 64'(0), 64'(1));
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy && w < 100) begin
      tick(1);
      w++;
    end
    chk_val(tag, 64'(busy), 64'(0));
  endtask

  initial begin
    // Reset values
    tick(1);
    chk_val("rst_valid", 64'(out_valid), 64'(0));
    chk_val("rst_ren",   64'(fifo_ren),  64'(0));
    chk_val("rst_data",  64'(out_data),  64'(0));
    chk_val("rst_count", 64'(out_count), 64'(0));
    chk_val("rst_busy",  64'(busy),      64'(0));
    tick(1);
    reset = 1'b0;
    tick(2);

    // Two full words
    out_ready = 1'b1;
    cap_base = cap_data.size();
    push_seq(8'h01, 8);
    wait_words(2, 100, waited);
    chk_val("t1_nwords", 64'(cap_data.size() - cap_base), 64'(2));
    chk_word("t1_w0", 0, 32'h04030201, 3'd4);
    chk_word("t1_w1", 1, 32'h08070605, 3'd4);
    wait_idle("t1_idle");

    // Idle timeout emits the trailing partial word
    cap_base = cap_data.size();
    push_seq(8'h01, 6);
    wait_words(1, 100, waited);
    chk_word("t2_w0", 0, 32'h04030201, 3'd4);
    wait_words(2, 80, waited);
    chk_word("t2_w1", 1, 32'h00000605, 3'd2);
    chk_val("t2_delay_in_range", 64'((waited >= 12) && (waited <= 30)), 64'(1));
    wait_idle("t2_idle");

    // Explicit flush of a partial word
    cap_base = cap_data.size();
    pop_base = pops;
    push_seq(8'h0A, 2);
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_words(1, 20, waited);
    chk_word("t3_w0", 0, 32'h00000B0A, 3'd2);
    wait_idle("t3_idle");
    chk_val("t3_pops", 64'(pops - pop_base), 64'(2));
    chk_val("t3_nwords", 64'(cap_data.size() - cap_base), 64'(1));

    // Backpressure: stall with a full accumulator, then drain in order
    out_ready = 1'b0;
    cap_base = cap_data.size();
    pop_base = pops;
    push_seq(8'h11, 12);
    tick(30);
    chk_val("t4_valid", 64'(out_valid), 64'(1));
    chk_val("t4_hold",  64'(out_data), 64'(32'h14131211));
    chk_val("t4_pops",  64'(pops - pop_base), 64'(8));
    chk_val("t4_fifo_left", 64'(fq.size()), 64'(4));
    out_ready = 1'b1;
    wait_words(3, 60, waited);
    chk_val("t4_nwords", 64'(cap_data.size() - cap_base), 64'(3));
    chk_word("t4_w0", 0, 32'h14131211, 3'd4);
    chk_word("t4_w1", 1, 32'h18171615, 3'd4);
    chk_word("t4_w2", 2, 32'h1C1B1A19, 3'd4);
    wait_idle("t4_idle");

    // Flush with nothing accumulated
    cap_base = cap_data.size();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    chk_val("t5_busy", 64'(busy), 64'(0));
    tick(10);
    chk_val("t5_nwords", 64'(cap_data.size() - cap_base), 64'(0));

    // Reset with two entries held and a third in flight
    cap_base = cap_data.size();
    pop_base = pops;
    push_seq(8'h21, 3);
    tick(1);
    chk_val("t6_busy_pre", 64'(busy), 64'(1));
    chk_val("t6_pops_pre", 64'(pops - pop_base), 64'(3));
    reset = 1'b1;
    tick(1);
    chk_val("t6_valid", 64'(out_valid), 64'(0));
    chk_val("t6_data",  64'(out_data),  64'(0));
    chk_val("t6_count", 64'(out_count), 64'(0));
    chk_val("t6_busy",  64'(busy),      64'(0));
    chk_val("t6_ren",   64'(fifo_ren),  64'(0));
    reset = 1'b0;
    tick(2);
    cap_base = cap_data.size();
    push_seq(8'h31, 4);
    wait_words(1, 40, waited);
    chk_word("t6_w0", 0, 32'h34333231, 3'd4);

    chk_val("no_underflow", 64'(underflows), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
